// File: rtl/shiftreg_seq.sv
// -----------------------------------------------------------------------------
// shiftreg_seq
//
// Sequencing controller for the 8-bit pixel shift register in the VGA timing
// path. A line-start command fetches len_i bytes from an upstream source over a
// req/ack handshake into a one-byte prefetch buffer. Each byte is then
// serialized as exactly 8 pixel slots (1 load + 7 shifts) on pixel-enable
// cycles. The register is blanked (loaded with 0x00) at line end and on
// underrun.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     line-start pulse, honoured only while idle
//   len_i       bytes per line, sampled with start_i (0 is legal)
//   pix_cen_i   pixel clock enable, one pixel slot per high cycle
//   req_o       byte request to the upstream source
//   ack_i       byte acknowledge, data_i valid while high
//   data_i      fetched byte
//   sr_data_o   shift register parallel load data
//   sr_load_o   shift register load strobe
//   sr_dir_o    shift register direction, constant DIR
//   sr_cen_o    shift register shift enable
//   busy_o      high whenever a line is in progress
//   done_o      one-cycle pulse when a line completes or aborts
//   underrun_o  sticky underrun flag, cleared by the next non-empty start
// -----------------------------------------------------------------------------
module shiftreg_seq #(
  parameter bit DIR = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] len_i,
  input  logic       pix_cen_i,
  output logic       req_o,
  input  logic       ack_i,
  input  logic [7:0] data_i,
  output logic [7:0] sr_data_o,
  output logic       sr_load_o,
  output logic       sr_dir_o,
  output logic       sr_cen_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_ABORT    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] fetch_left_q, fetch_left_d;
  logic [7:0] load_left_q, load_left_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] buf_q, buf_d;
  logic       full_q, full_d;
  logic       req_q, req_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic       ack_take;

  always_comb begin
    state_d      = state_q;
    fetch_left_d = fetch_left_q;
    load_left_d  = load_left_q;
    bit_cnt_d    = bit_cnt_q;
    buf_d        = buf_q;
    full_d       = full_q;
    req_d        = req_q;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    sr_load_o    = 1'b0;
    sr_cen_o     = 1'b0;
    sr_data_o    = 8'h00;

    // A byte is only taken while a request is outstanding; a stray ack is
    // ignored. While req_q is high the buffer is always empty, so the capture
    // can never collide with a load that empties the buffer.
    ack_take = req_q & ack_i;
    if (ack_take) begin
      buf_d        = data_i;
      full_d       = 1'b1;
      fetch_left_d = fetch_left_q - 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != 8'd0) begin
            fetch_left_d = len_i;
            load_left_d  = len_i;
            bit_cnt_d    = 3'd0;
            full_d       = 1'b0;
            underrun_d   = 1'b0;
            state_d      = ST_PREFETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_PREFETCH: begin
        if (full_q) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (pix_cen_i) begin
          if (bit_cnt_q == 3'd0) begin
            sr_load_o = 1'b1;
            if (load_left_q != 8'd0) begin
              if (full_q) begin
                sr_data_o   = buf_q;
                full_d      = 1'b0;
                load_left_d = load_left_q - 8'd1;
                bit_cnt_d   = 3'd1;
              end else begin
                // Byte not there in time: blank the register and abort.
                underrun_d = 1'b1;
                state_d    = ST_ABORT;
              end
            end else begin
              // Slot after the last byte's 7th shift: blank and finish.
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            sr_cen_o  = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      ST_ABORT: begin
        // An outstanding request must still be completed; the byte it
        // returns is dropped along with the rest of the line.
        if (!req_q || ack_i) begin
          fetch_left_d = 8'd0;
          load_left_d  = 8'd0;
          bit_cnt_d    = 3'd0;
          full_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Request holds until acked; otherwise it rises as soon as the buffer is
    // (or is about to be) empty and bytes remain, which lets the next fetch
    // start in the cycle right after a load.
    if (req_q) begin
      req_d = ~ack_i;
    end else begin
      req_d = ((state_d == ST_PREFETCH) || (state_d == ST_RUN)) &&
              !full_d && (fetch_left_d != 8'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      fetch_left_q <= 8'd0;
      load_left_q  <= 8'd0;
      bit_cnt_q    <= 3'd0;
      full_q       <= 1'b0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_left_q <= fetch_left_d;
      load_left_q  <= load_left_d;
      bit_cnt_q    <= bit_cnt_d;
      full_q       <= full_d;
      req_q        <= req_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Buffer contents are qualified by full_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  assign req_o      = req_q;
  assign sr_dir_o   = DIR;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_shiftreg_seq.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_seq
//
// Self-checking bench for shiftreg_seq: a per-cycle vector table for the
// single-byte line, plus hand-written multi-cycle sequences (reset, zero
// length, throttled pixels, underrun, busy start, prefetch overlap, reset
// mid-line) driven through a small byte-source responder and slot model.
// -----------------------------------------------------------------------------
module tb_shiftreg_seq;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] len_i;
  logic       pix_cen_i;
  logic       req_o;
  logic       ack_i;
  logic [7:0] data_i;
  logic [7:0] sr_data_o;
  logic       sr_load_o;
  logic       sr_dir_o;
  logic       sr_cen_o;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  shiftreg_seq dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .len_i      (len_i),
    .pix_cen_i  (pix_cen_i),
    .req_o      (req_o),
    .ack_i      (ack_i),
    .data_i     (data_i),
    .sr_data_o  (sr_data_o),
    .sr_load_o  (sr_load_o),
    .sr_dir_o   (sr_dir_o),
    .sr_cen_o   (sr_cen_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       ack;
    logic [7:0] data;
    logic       req;
    logic       load;
    logic       cen;
    logic [7:0] sd;
    logic       busy;
    logic       done;
    logic       und;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] src_bytes[$];
  int         src_delay[$];
  logic [7:0] exp_loads[$];

  function automatic vec_t mkv(input logic st, input logic ack, input logic [7:0] d,
                               input logic req, input logic ld, input logic cen,
                               input logic [7:0] sd, input logic busy,
                               input logic done, input logic und);
    vec_t v;
    v.start = st; v.ack = ack; v.data = d;
    v.req = req; v.load = ld; v.cen = cen; v.sd = sd;
    v.busy = busy; v.done = done; v.und = und;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] outs_now();
    return {req_o, sr_load_o, sr_cen_o, sr_data_o, busy_o, done_o, underrun_o};
  endfunction

  // Runs one line from the start pulse until two cycles after done_o, with a
  // byte source that acks after src_delay[i] cycles of req (or acks
  // permanently), and compares every active pixel slot against the model:
  // slot s is a load of exp_loads[s/8] when s%8==0, a shift otherwise.
  task automatic run_line(input string name, input int len, input int pix_per,
                          input bit perm_ack, input bit busy_start,
                          input bit chk_reassert, input bit chk_abort,
                          input int exp_acks, input bit exp_und);
    int total, slot, cyc, budget, idx, wait_cnt;
    int ev_err, acks, dones, ctrl_err, hs_err, re_err;
    int last_ack_cyc, done_cyc, bad_slot;
    bit prev_req, prev_ack, need_req;
    logic [8:0] act_ev, exp_ev, bad_act, bad_exp;
    total = 8 * (exp_loads.size() - 1) + 1;
    budget = (len + 2) * 8 * pix_per + 100;
    slot = 0; cyc = 0; idx = 0; wait_cnt = 0;
    ev_err = 0; acks = 0; dones = 0; ctrl_err = 0; hs_err = 0; re_err = 0;
    last_ack_cyc = -1; done_cyc = -1; bad_slot = -1;
    prev_req = 1'b0; prev_ack = 1'b0; need_req = 1'b0;
    bad_act = '0; bad_exp = '0;
    while (cyc < budget && !(dones > 0 && cyc > done_cyc + 2)) begin
      start_i   = (cyc == 0) || (busy_start && slot > 0 && slot < total && (cyc % 5) == 0);
      len_i     = (cyc == 0) ? 8'(len) : 8'd7;
      pix_cen_i = (cyc % pix_per) == 0;
      if (perm_ack) begin
        ack_i  = 1'b1;
        data_i = (idx < src_bytes.size()) ? src_bytes[idx] : 8'hEE;
      end else if (req_o && idx < src_bytes.size() && wait_cnt >= src_delay[idx]) begin
        ack_i  = 1'b1;
        data_i = src_bytes[idx];
      end else begin
        ack_i  = 1'b0;
        data_i = 8'h00;
      end
      #1;
      if (prev_req && !prev_ack && !req_o) hs_err++;
      if (need_req && !req_o) re_err++;
      need_req = 1'b0;
      if ((sr_load_o && sr_cen_o) || ((sr_load_o || sr_cen_o) && !pix_cen_i)) ctrl_err++;
      if (pix_cen_i && !(sr_load_o || sr_cen_o) && slot > 0 && slot < total) ctrl_err++;
      if (sr_load_o || sr_cen_o) begin
        act_ev = sr_load_o ? {1'b1, sr_data_o} : 9'h000;
        if (slot >= total) exp_ev = 9'h1FF;
        else if ((slot % 8) == 0) exp_ev = {1'b1, exp_loads[slot / 8]};
        else exp_ev = 9'h000;
        if (slot >= total || act_ev != exp_ev) begin
          ev_err++;
          if (bad_slot < 0) begin
            bad_slot = slot; bad_act = act_ev; bad_exp = exp_ev;
          end
        end
        if (chk_reassert && sr_load_o && (slot / 8) < len - 1) need_req = 1'b1;
        slot++;
      end
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      if (req_o && ack_i) begin
        acks++; idx++; last_ack_cyc = cyc; wait_cnt = 0;
      end else if (req_o) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      prev_req = req_o;
      prev_ack = ack_i;
      step();
      cyc++;
    end
    start_i = 1'b0; ack_i = 1'b0; pix_cen_i = 1'b0; data_i = 8'h00;
    #1;
    check({name, " slot count"}, slot, total);
    n_tests++;
    if (ev_err != 0) begin
      n_fail++;
      $display("FAIL %s events: slot %0d got {load,data}=0x%0h, expected 0x%0h (%0d bad slots)",
               name, bad_slot, bad_act, bad_exp, ev_err);
    end
    check({name, " load/cen gating"}, ctrl_err, 0);
    check({name, " done pulses"}, dones, 1);
    check({name, " acks consumed"}, acks, exp_acks);
    check({name, " req held until ack"}, hs_err, 0);
    check({name, " underrun_o"}, underrun_o, exp_und);
    check({name, " busy_o after line"}, busy_o, 1'b0);
    if (chk_reassert) check({name, " req re-assert after load"}, re_err, 0);
    if (chk_abort) check({name, " done cycle after late ack"}, done_cyc, last_ack_cyc + 1);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; len_i = 8'd0; pix_cen_i = 1'b0;
    ack_i = 1'b0; data_i = 8'h00;

    // ---------------- reset state ----------------
    #3;
    check("dir during reset", sr_dir_o, 1'b1);
    check("outputs during reset", outs_now(), 14'h0);
    step(); step();
    rst_ni = 1'b1;
    step();
    check("outputs after reset", outs_now(), 14'h0);

    // ---------------- single byte, table driven ----------------
    vecs.push_back(mkv(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0)); // start accepted
    vecs.push_back(mkv(0, 1, 8'hA5, 1, 0, 0, 8'h00, 1, 0, 0)); // req up, ack
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0)); // full, req down
    vecs.push_back(mkv(0, 0, 8'h00, 0, 1, 0, 8'hA5, 1, 0, 0)); // slot 1 load
    for (int i = 0; i < 7; i++)
      vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0)); // slots 2..8
    vecs.push_back(mkv(0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0)); // slot 9 blank
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0)); // done
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mkv(0, 1, 8'h5C, 0, 0, 0, 8'h00, 0, 0, 0)); // stray ack
    vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      logic [13:0] act, exp;
      start_i = vecs[i].start; len_i = 8'd1; pix_cen_i = 1'b1;
      ack_i = vecs[i].ack; data_i = vecs[i].data;
      #1;
      act = {req_o, sr_load_o, sr_cen_o, (vecs[i].load ? sr_data_o : 8'h00),
             busy_o, done_o, underrun_o};
      exp = {vecs[i].req, vecs[i].load, vecs[i].cen, vecs[i].sd,
             vecs[i].busy, vecs[i].done, vecs[i].und};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL single-byte row %0d: got {req,ld,cen,data,busy,done,und}=0x%0h, expected 0x%0h",
                 i, act, exp);
      end
      step();
    end
    start_i = 1'b0; ack_i = 1'b0; pix_cen_i = 1'b0;

    // ---------------- throttled pixels ----------------
    src_bytes = '{8'h01, 8'h80, 8'hFF};
    src_delay = '{0, 0, 0};
    exp_loads = '{8'h01, 8'h80, 8'hFF, 8'h00};
    run_line("throttled", 3, 4, 0, 0, 0, 0, 3, 0);

    // ---------------- underrun ----------------
    src_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    src_delay = '{0, 20, 0, 0};
    exp_loads = '{8'h11, 8'h00};
    run_line("underrun", 4, 1, 0, 0, 0, 1, 2, 1);
    for (int i = 0; i < 5; i++) step();
    check("underrun sticky while idle", underrun_o, 1'b1);

    // ---------------- zero length ----------------
    start_i = 1'b1; len_i = 8'd0; pix_cen_i = 1'b1;
    #1;
    check("zero-len before edge req", req_o, 1'b0);
    step();
    start_i = 1'b0;
    #1;
    check("zero-len done/busy/req", {done_o, busy_o, req_o}, 3'b100);
    step();
    check("zero-len done drops", {done_o, busy_o, req_o}, 3'b000);
    pix_cen_i = 1'b0;

    // ---------------- start pulses while busy ----------------
    src_bytes = '{8'h5A, 8'hC3};
    src_delay = '{1, 2};
    exp_loads = '{8'h5A, 8'hC3, 8'h00};
    run_line("busy-start", 2, 1, 0, 1, 0, 0, 2, 0);

    // ---------------- prefetch overlap, ack held high ----------------
    src_bytes.delete();
    exp_loads.delete();
    for (int i = 0; i < 255; i++) begin
      src_bytes.push_back(8'(i + 1));
      exp_loads.push_back(8'(i + 1));
    end
    exp_loads.push_back(8'h00);
    src_delay.delete();
    for (int i = 0; i < 255; i++) src_delay.push_back(0);
    run_line("overlap", 255, 1, 1, 0, 1, 0, 255, 0);

    // ---------------- reset mid-line ----------------
    start_i = 1'b1; len_i = 8'd2; pix_cen_i = 1'b1; ack_i = 1'b0; data_i = 8'h00;
    step();
    start_i = 1'b0; ack_i = 1'b1; data_i = 8'h77;
    #1;
    check("midreset req before ack", req_o, 1'b1);
    step();
    ack_i = 1'b0; data_i = 8'h00;
    step();
    step();
    step();
    #1;
    check("midreset pre {req,ld,cen,busy}", {req_o, sr_load_o, sr_cen_o, busy_o}, 4'b1011);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midreset async outputs", outs_now(), 14'h0);
    check("midreset dir", sr_dir_o, 1'b1);
    step();
    rst_ni = 1'b1;
    step();
    check("after midreset outputs", outs_now(), 14'h0);
    pix_cen_i = 1'b0;
    src_bytes = '{8'h3C};
    src_delay = '{0};
    exp_loads = '{8'h3C, 8'h00};
    run_line("restart", 1, 1, 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
